bp_update_ctrl: RTL and testbench
=================================

Name: bp_update_ctrl

Overview:
Sequencer for the branch pattern table, which holds 2^IDX_W saturating counters; a counter value >= 2^(CTR_W-1) predicts taken. After reset it sweeps the table to a known value. It then queues in-flight predictions from fetch in an in-order FIFO. On each in-order resolution from execute it performs a read-modify-write of the counter and reports mispredicts. It is the single owner of the table write port.

Parameters:
IDX_W, 10, table index width (table depth 2^IDX_W)
CTR_W, 3, counter width
DEPTH, 8, in-flight prediction FIFO entries (power of 2, >= 2)
INIT_VAL, 3, counter value written during init sweep (weakly not-taken)

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
pred_valid  in  1  fetch presents a prediction
pred_ready  out  1  prediction can be accepted
pred_idx  in  IDX_W  table index used for the prediction
pred_taken  in  1  predicted direction
resolve_valid  in  1  oldest outstanding branch resolved
resolve_taken  in  1  actual direction
flush  in  1  discard all queued predictions
tbl_rd_idx  out  IDX_W  table read index
tbl_rd_data  in  CTR_W  counter at tbl_rd_idx (combinational read)
tbl_wr_en  out  1  table write strobe
tbl_wr_idx  out  IDX_W  table write index
tbl_wr_data  out  CTR_W  table write data
init_done  out  1  init sweep complete
mispredict  out  1  one-cycle pulse; resolved direction != predicted
misp_idx  out  IDX_W  index of the mispredicted branch
occupancy  out  log2(DEPTH)+1  queued entries
misp_count  out  16  saturating mispredict counter
resolve_err  out  1  sticky; resolve_valid seen with empty queue

Behaviour:
- Reset (async, any state): FSM=INIT, sweep ptr=0, FIFO empty, U1 stage invalid. All outputs 0, except tbl_wr_en=1 and tbl_wr_data=INIT_VAL (INIT drives them immediately).
- INIT: each cycle tbl_wr_en=1, tbl_wr_idx=sweep ptr, tbl_wr_data=INIT_VAL, ptr++. After writing index 2^IDX_W-1 -> RUN next cycle. Sweep takes exactly 2^IDX_W cycles. pred_ready=0 throughout. Reset mid-sweep restarts at 0.
- RUN: init_done=1. Stays in RUN until reset.
- pred_ready = RUN && occupancy<DEPTH. The value comes from registered count only; a same-cycle pop does not free space for a push.
- Push on pred_valid&&pred_ready: store {pred_idx, pred_taken} at tail.
- Resolve on resolve_valid:
  - Queue empty (including INIT): ignored, resolve_err<=1 (cleared only by reset).
  - Otherwise pop the head and load U1 with {idx, pred_taken, resolve_taken}.
- U1 (cycle after resolve):
  - tbl_rd_idx=tbl_wr_idx=U1.idx, tbl_wr_en=1.
  - tbl_wr_data = taken ? min(rd+1, 2^CTR_W-1) : max(rd-1, 0).
  - mispredict=1 and misp_idx=U1.idx when pred != actual. misp_count increments, saturating at 0xFFFF.
  - Latency resolve->write/mispredict = 1 cycle. Back-to-back resolves to the same index are correct without forwarding: each write lands before the next U1 read.
- Outside U1 in RUN: tbl_wr_en=0, mispredict=0. tbl_rd_idx holds its last value.
- Simultaneous push+pop, nonempty and not full: both occur, occupancy unchanged.
- Push and pop with an empty queue: push accepted, resolve flagged as error.
- Flush: pointers and occupancy <=0 at the edge.
  - A same-cycle resolve is processed first: head popped, U1 loaded, update completes.
  - A same-cycle push is dropped.
  - An already-valid U1 completes normally.
- Pointers wrap modulo DEPTH. Occupancy is never >DEPTH and never <0.

Test Plan:
- Reset release, IDX_W=10 -> tbl_wr_en=1 for 1024 cycles, idx 0..1023, data 3; init_done=1 in cycle 1025; pred_ready=0 before that.
- Push idx 5 pred_taken=0; resolve taken=1 with tbl_rd_data=3 -> next cycle wr idx 5 data 4, mispredict=1, misp_idx=5, misp_count=1.
- Saturation: resolve taken with rd_data=7 -> wr_data 7; resolve not-taken with rd_data=0 -> wr_data 0; pred matches outcome -> mispredict=0.
- Push 8 entries -> pred_ready=0, occupancy=8. Push+resolve in the same cycle while full -> push rejected, occupancy 7. Then 7 resolves in FIFO order show the correct idx sequence on tbl_wr_idx.
- Flush asserted with resolve and push in the same cycle, occupancy=3 -> head updated next cycle, occupancy=0, pushed entry absent.
- Resolve with empty queue -> no table write, resolve_err=1 and stays 1. Assert rst_n=0 mid-run -> all outputs reset and the sweep restarts from idx 0.

Source files
------------

// File: rtl/bp_update_ctrl_if.sv
// -----------------------------------------------------------------------------
// bp_update_ctrl_if
// Bundles the fetch/execute handshake and the pattern-table port used by
// bp_update_ctrl.
//   slave  : the update controller (accepts predictions/resolves, owns the
//            table write port, reads the table combinationally)
//   master : the environment (fetch, execute, table storage)
// Signals:
//   pred_valid/pred_ready/pred_idx/pred_taken : prediction push handshake
//   resolve_valid/resolve_taken               : in-order resolution
//   flush                                     : discard queued predictions
//   tbl_rd_idx/tbl_rd_data                    : combinational table read
//   tbl_wr_en/tbl_wr_idx/tbl_wr_data          : table write port
// -----------------------------------------------------------------------------
interface bp_update_ctrl_if #(
    parameter int IDX_W = 10,
    parameter int CTR_W = 3
);
    logic             pred_valid;
    logic             pred_ready;
    logic [IDX_W-1:0] pred_idx;
    logic             pred_taken;
    logic             resolve_valid;
    logic             resolve_taken;
    logic             flush;
    logic [IDX_W-1:0] tbl_rd_idx;
    logic [CTR_W-1:0] tbl_rd_data;
    logic             tbl_wr_en;
    logic [IDX_W-1:0] tbl_wr_idx;
    logic [CTR_W-1:0] tbl_wr_data;

    modport master (
        output pred_valid, pred_idx, pred_taken,
        output resolve_valid, resolve_taken, flush,
        output tbl_rd_data,
        input  pred_ready, tbl_rd_idx, tbl_wr_en, tbl_wr_idx, tbl_wr_data
    );

    modport slave (
        input  pred_valid, pred_idx, pred_taken,
        input  resolve_valid, resolve_taken, flush,
        input  tbl_rd_data,
        output pred_ready, tbl_rd_idx, tbl_wr_en, tbl_wr_idx, tbl_wr_data
    );
endinterface

// File: rtl/bp_update_ctrl.sv
// -----------------------------------------------------------------------------
// bp_update_ctrl
// Sole owner of the branch pattern table write port. After reset it sweeps the
// whole table to INIT_VAL, then queues in-flight predictions in an in-order
// FIFO and, on each resolution, performs a read-modify-write of the 2-bit-style
// saturating counter one cycle later (stage U1), flagging mispredicts.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   bus          : handshake + table port (slave modport)
//   init_done    : sweep complete, controller in RUN
//   mispredict   : one-cycle pulse in U1 when predicted != actual
//   misp_idx     : index of the mispredicted branch (0 when no pulse)
//   occupancy    : queued predictions
//   misp_count   : saturating mispredict counter
//   resolve_err  : sticky, resolve seen with an empty queue
// -----------------------------------------------------------------------------
module bp_update_ctrl #(
    parameter int IDX_W    = 10,
    parameter int CTR_W    = 3,
    parameter int DEPTH    = 8,
    parameter int INIT_VAL = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    bp_update_ctrl_if.slave          bus,
    output logic                     init_done,
    output logic                     mispredict,
    output logic [IDX_W-1:0]         misp_idx,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [15:0]              misp_count,
    output logic                     resolve_err
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Saturating counter step: toward max on taken, toward zero on not-taken.
    function automatic logic [CTR_W-1:0] ctr_next(input logic [CTR_W-1:0] cur,
                                                  input logic             taken);
        logic [CTR_W-1:0] res;
        if (taken) begin
            res = (cur == {CTR_W{1'b1}}) ? cur : cur + {{(CTR_W-1){1'b0}}, 1'b1};
        end else begin
            res = (cur == {CTR_W{1'b0}}) ? cur : cur - {{(CTR_W-1){1'b0}}, 1'b1};
        end
        return res;
    endfunction

    logic [0:0]       state_q,    state_d;
    logic [IDX_W-1:0] sweep_q,    sweep_d;
    logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
    logic [OCC_W-1:0] count_q,    count_d;
    logic             u1_valid_q, u1_valid_d;
    logic [IDX_W-1:0] u1_idx_q,   u1_idx_d;
    logic             u1_pred_q,  u1_pred_d;
    logic             u1_act_q,   u1_act_d;
    logic [15:0]      misp_cnt_q, misp_cnt_d;
    logic             err_q,      err_d;

    logic [IDX_W-1:0] fifo_idx_q [DEPTH];
    logic             fifo_tk_q  [DEPTH];

    logic             run_s, pred_ready_s, push_s, pop_s, head_tk_s;
    logic [IDX_W-1:0] head_idx_s;

    // Handshake qualification; ready uses only the registered count.
    always_comb begin
        run_s        = (state_q == ST_RUN);
        pred_ready_s = run_s && (count_q < OCC_W'(DEPTH));
        push_s       = bus.pred_valid && pred_ready_s && !bus.flush;
        pop_s        = bus.resolve_valid && (count_q != {OCC_W{1'b0}});
        head_idx_s   = fifo_idx_q[rd_ptr_q];
        head_tk_s    = fifo_tk_q[rd_ptr_q];
    end

    // Next-state: sweep, FIFO pointers/count, U1 load, statistics.
    always_comb begin
        state_d    = state_q;
        sweep_d    = sweep_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        u1_valid_d = pop_s;
        u1_idx_d   = u1_idx_q;
        u1_pred_d  = u1_pred_q;
        u1_act_d   = u1_act_q;
        misp_cnt_d = misp_cnt_q;
        err_d      = err_q | (bus.resolve_valid && !pop_s);

        if (state_q == ST_INIT) begin
            sweep_d = sweep_q + {{(IDX_W-1){1'b0}}, 1'b1};
            if (sweep_q == {IDX_W{1'b1}}) begin
                state_d = ST_RUN;
            end else begin
                state_d = ST_INIT;
            end
        end else begin
            sweep_d = sweep_q;
        end

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        // A popped entry moves into U1; tbl_rd_idx keeps the last U1 index.
        if (pop_s) begin
            rd_ptr_d  = rd_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
            u1_idx_d  = head_idx_s;
            u1_pred_d = head_tk_s;
            u1_act_d  = bus.resolve_taken;
            if ((head_tk_s != bus.resolve_taken) && (misp_cnt_q != 16'hFFFF)) begin
                misp_cnt_d = misp_cnt_q + 16'd1;
            end else begin
                misp_cnt_d = misp_cnt_q;
            end
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + {{(OCC_W-1){1'b0}}, 1'b1};
            2'b01:   count_d = count_q - {{(OCC_W-1){1'b0}}, 1'b1};
            default: count_d = count_q;
        endcase

        // Flush wins over pointer movement; a same-cycle pop still loads U1.
        if (bus.flush) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            count_d  = {OCC_W{1'b0}};
        end else begin
            count_d  = count_d;
        end
    end

    // Control and status state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            sweep_q    <= {IDX_W{1'b0}};
            wr_ptr_q   <= {PTR_W{1'b0}};
            rd_ptr_q   <= {PTR_W{1'b0}};
            count_q    <= {OCC_W{1'b0}};
            u1_valid_q <= 1'b0;
            u1_idx_q   <= {IDX_W{1'b0}};
            u1_pred_q  <= 1'b0;
            u1_act_q   <= 1'b0;
            misp_cnt_q <= 16'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sweep_q    <= sweep_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            u1_valid_q <= u1_valid_d;
            u1_idx_q   <= u1_idx_d;
            u1_pred_q  <= u1_pred_d;
            u1_act_q   <= u1_act_d;
            misp_cnt_q <= misp_cnt_d;
            err_q      <= err_d;
        end
    end

    // FIFO payload storage; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_idx_q[wr_ptr_q] <= bus.pred_idx;
            fifo_tk_q[wr_ptr_q]  <= bus.pred_taken;
        end
    end

    // Table write port: sweep in INIT, read-modify-write in U1.
    always_comb begin
        bus.tbl_wr_en   = 1'b0;
        bus.tbl_wr_idx  = u1_idx_q;
        bus.tbl_wr_data = {CTR_W{1'b0}};
        case (state_q)
            ST_INIT: begin
                bus.tbl_wr_en   = 1'b1;
                bus.tbl_wr_idx  = sweep_q;
                bus.tbl_wr_data = CTR_W'(INIT_VAL);
            end
            ST_RUN: begin
                if (u1_valid_q) begin
                    bus.tbl_wr_en   = 1'b1;
                    bus.tbl_wr_data = ctr_next(bus.tbl_rd_data, u1_act_q);
                end else begin
                    bus.tbl_wr_en   = 1'b0;
                end
            end
            default: begin
                bus.tbl_wr_en   = 1'b0;
            end
        endcase
    end

    assign bus.pred_ready = pred_ready_s;
    assign bus.tbl_rd_idx = u1_idx_q;
    assign init_done      = run_s;
    assign mispredict     = run_s && u1_valid_q && (u1_pred_q != u1_act_q);
    assign misp_idx       = mispredict ? u1_idx_q : {IDX_W{1'b0}};
    assign occupancy      = count_q;
    assign misp_count     = misp_cnt_q;
    assign resolve_err    = err_q;

endmodule

// File: tb/tb_bp_update_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bp_update_ctrl
// Directed bench for bp_update_ctrl. A behavioural model (queue of predictions,
// reference counter table, pending update) predicts every output each cycle and
// is compared on the falling edge; literal expectations pin key scenarios.
// -----------------------------------------------------------------------------
module tb_bp_update_ctrl;
    localparam int IDX_W    = 10;
    localparam int CTR_W    = 3;
    localparam int DEPTH    = 8;
    localparam int INIT_VAL = 3;
    localparam int TBL      = 1 << IDX_W;
    localparam int CMAX     = (1 << CTR_W) - 1;

    logic clk;
    logic rst_n;

    logic                 init_done;
    logic                 mispredict;
    logic [IDX_W-1:0]     misp_idx;
    logic [$clog2(DEPTH):0] occupancy;
    logic [15:0]          misp_count;
    logic                 resolve_err;

    bp_update_ctrl_if #(.IDX_W(IDX_W), .CTR_W(CTR_W)) bus ();

    bp_update_ctrl #(.IDX_W(IDX_W), .CTR_W(CTR_W), .DEPTH(DEPTH), .INIT_VAL(INIT_VAL)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .init_done   (init_done),
        .mispredict  (mispredict),
        .misp_idx    (misp_idx),
        .occupancy   (occupancy),
        .misp_count  (misp_count),
        .resolve_err (resolve_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Table storage owned by the bench.
    logic [CTR_W-1:0] mem [TBL];
    assign bus.tbl_rd_data = mem[bus.tbl_rd_idx];
    always @(posedge clk) begin
        if (bus.tbl_wr_en === 1'b1) mem[bus.tbl_wr_idx] <= bus.tbl_wr_data;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct { int idx; bit tk; } ent_t;
    ent_t q[$];
    bit   m_init;
    int   m_sweep;
    bit   p_v;
    int   p_idx;
    bit   p_pred, p_act;
    int   m_misp;
    bit   m_err;
    int   m_last;
    int   ref_tbl [TBL];
    int   sz;
    bit   rdy;
    ent_t e;

    function automatic int sat(input int v, input bit tk);
        int n;
        n = tk ? v + 1 : v - 1;
        if (n > CMAX) n = CMAX;
        if (n < 0) n = 0;
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_init = 1'b1; m_sweep = 0; q.delete(); p_v = 1'b0; p_idx = 0;
            p_pred = 1'b0; p_act = 1'b0; m_misp = 0; m_err = 1'b0; m_last = 0;
        end else begin
            sz  = q.size();
            rdy = !m_init && (sz < DEPTH);
            if (m_init) begin
                ref_tbl[m_sweep] = INIT_VAL;
                if (m_sweep == TBL - 1) m_init = 1'b0;
                m_sweep++;
            end
            if (p_v) ref_tbl[p_idx] = sat(ref_tbl[p_idx], p_act);
            p_v = 1'b0;
            if (bus.resolve_valid) begin
                if (sz == 0) m_err = 1'b1;
                else begin
                    e = q.pop_front();
                    p_v = 1'b1; p_idx = e.idx; p_pred = e.tk; p_act = bus.resolve_taken;
                    m_last = e.idx;
                    if (p_pred != p_act && m_misp < 65535) m_misp++;
                end
            end
            if (bus.pred_valid && rdy && !bus.flush)
                q.push_back('{idx: int'(bus.pred_idx), tk: bus.pred_taken});
            if (bus.flush) q.delete();
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        chk("init_done", 32'(init_done), 32'(!m_init));
        chk("pred_ready", 32'(bus.pred_ready), 32'(!m_init && q.size() < DEPTH));
        chk("occupancy", 32'(occupancy), 32'(q.size()));
        chk("wr_en", 32'(bus.tbl_wr_en), 32'(m_init || p_v));
        chk("rd_idx", 32'(bus.tbl_rd_idx), 32'(m_last));
        if (m_init) begin
            chk("sweep_idx", 32'(bus.tbl_wr_idx), 32'(m_sweep));
            chk("sweep_data", 32'(bus.tbl_wr_data), 32'(INIT_VAL));
        end else if (p_v) begin
            chk("upd_idx", 32'(bus.tbl_wr_idx), 32'(p_idx));
            chk("upd_data", 32'(bus.tbl_wr_data), 32'(sat(ref_tbl[p_idx], p_act)));
        end
        chk("mispredict", 32'(mispredict), 32'(p_v && (p_pred != p_act)));
        if (p_v && (p_pred != p_act)) chk("misp_idx", 32'(misp_idx), 32'(p_idx));
        chk("misp_count", 32'(misp_count), 32'(m_misp));
        chk("resolve_err", 32'(resolve_err), 32'(m_err));
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic pv, input int pidx, input logic ptk,
                         input logic rv, input logic rtk, input logic fl);
        bus.pred_valid    = pv;
        bus.pred_idx      = IDX_W'(pidx);
        bus.pred_taken    = ptk;
        bus.resolve_valid = rv;
        bus.resolve_taken = rtk;
        bus.flush         = fl;
        @(posedge clk);
        #1;
        bus.pred_valid    = 1'b0;
        bus.pred_idx      = '0;
        bus.pred_taken    = 1'b0;
        bus.resolve_valid = 1'b0;
        bus.resolve_taken = 1'b0;
        bus.flush         = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        bus.pred_valid = 1'b0; bus.pred_idx = '0; bus.pred_taken = 1'b0;
        bus.resolve_valid = 1'b0; bus.resolve_taken = 1'b0; bus.flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wr_en", 32'(bus.tbl_wr_en), 32'd1);
        chk("rst_wr_data", 32'(bus.tbl_wr_data), 32'd3);
        chk("rst_init_done", 32'(init_done), 32'd0);
        rst_n = 1'b1;

        // Init sweep: 1024 writes, RUN afterwards.
        repeat (TBL - 1) @(posedge clk);
        #1;
        chk("sweep_last_idx", 32'(bus.tbl_wr_idx), 32'd1023);
        chk("sweep_not_done", 32'(init_done), 32'd0);
        chk("sweep_no_ready", 32'(bus.pred_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("init_done_1025", 32'(init_done), 32'd1);
        chk("run_wr_en", 32'(bus.tbl_wr_en), 32'd0);

        // Basic mispredict update.
        drive(1'b1, 5, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("t1_wr_idx", 32'(bus.tbl_wr_idx), 32'd5);
        chk("t1_wr_data", 32'(bus.tbl_wr_data), 32'd4);
        chk("t1_misp", 32'(mispredict), 32'd1);
        chk("t1_misp_idx", 32'(misp_idx), 32'd5);
        chk("t1_misp_cnt", 32'(misp_count), 32'd1);
        drive(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Saturation high: 3->4->5->6->7->7.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 7, 1'b1, 1'b0, 1'b0, 1'b0);
            drive(1'b0, 0, 1'b0, 1'b1, 1'b1, 1'b0);
        end
        chk("sat_hi_rd", 32'(bus.tbl_rd_data), 32'd7);
        chk("sat_hi_wr", 32'(bus.tbl_wr_data), 32'd7);
        chk("sat_hi_misp", 32'(mispredict), 32'd0);
        // Saturation low: 3->2->1->0->0.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 9, 1'b0, 1'b0, 1'b0, 1'b0);
            drive(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        chk("sat_lo_rd", 32'(bus.tbl_rd_data), 32'd0);
        chk("sat_lo_wr", 32'(bus.tbl_wr_data), 32'd0);
        chk("sat_lo_misp", 32'(mispredict), 32'd0);
        drive(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Fill the queue, then push+resolve while full.
        for (int i = 0; i < DEPTH; i++) drive(1'b1, 100 + i, i[0], 1'b0, 1'b0, 1'b0);
        chk("full_occ", 32'(occupancy), 32'd8);
        chk("full_ready", 32'(bus.pred_ready), 32'd0);
        drive(1'b1, 200, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("full_pushpop_occ", 32'(occupancy), 32'd7);
        chk("full_first_idx", 32'(bus.tbl_wr_idx), 32'd100);
        for (int k = 1; k < DEPTH; k++) begin
            drive(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
            chk("order_idx", 32'(bus.tbl_wr_idx), 32'(100 + k));
        end
        chk("drained_occ", 32'(occupancy), 32'd0);
        drive(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Flush with concurrent resolve and push.
        for (int i = 0; i < 3; i++) drive(1'b1, 300 + i, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("pre_flush_occ", 32'(occupancy), 32'd3);
        drive(1'b1, 400, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("flush_occ", 32'(occupancy), 32'd0);
        chk("flush_upd_idx", 32'(bus.tbl_wr_idx), 32'd300);
        chk("flush_upd_en", 32'(bus.tbl_wr_en), 32'd1);
        chk("flush_misp", 32'(mispredict), 32'd1);
        chk("flush_no_err", 32'(resolve_err), 32'd0);
        drive(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Resolve on empty queue.
        drive(1'b0, 0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("empty_no_wr", 32'(bus.tbl_wr_en), 32'd0);
        chk("empty_err", 32'(resolve_err), 32'd1);
        // Push and resolve together with empty queue.
        drive(1'b1, 12, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("empty_pushpop_occ", 32'(occupancy), 32'd1);
        chk("empty_pushpop_wr", 32'(bus.tbl_wr_en), 32'd0);
        drive(1'b0, 0, 1'b0, 1'b1, 1'b1, 1'b0);
        repeat (3) drive(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("err_sticky", 32'(resolve_err), 32'd1);

        // Mid-run reset restarts the sweep.
        drive(1'b1, 20, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_done", 32'(init_done), 32'd0);
        chk("mid_rst_err", 32'(resolve_err), 32'd0);
        chk("mid_rst_cnt", 32'(misp_count), 32'd0);
        chk("mid_rst_occ", 32'(occupancy), 32'd0);
        chk("mid_rst_wr_en", 32'(bus.tbl_wr_en), 32'd1);
        chk("mid_rst_wr_idx", 32'(bus.tbl_wr_idx), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("resweep_idx", 32'(bus.tbl_wr_idx), 32'd3);
        repeat (TBL) @(posedge clk);
        #1;
        chk("resweep_done", 32'(init_done), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
